tt_sweep_checker: RTL and testbench

- Synthesizable exhaustive truth-table sweep engine. It drives every input vector 0..2^N_IN-1 into N_CH parallel implementations of one Boolean function (e.g. DKNF and DDNF forms) and compares each against a golden table ROM.
- Counts mismatches, captures the first failure and reports pass/fail through a start/done handshake.
- Used in hardware self-test and as a bench-reusable checker for generated logic blocks.

---
 rtl/tt_sweep_checker.sv | 118 +++++++++++
 tb/tb_tt_sweep_checker.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep: drives every vector into N_CH implementations and checks each one against a golden ROM.
// Each vector runs APPLY -> SETTLE x SETTLE -> CHECK. The module counts failing vectors and captures the first failure.
module tt_sweep_checker #(
  parameter int N_IN         = 9,
  parameter int N_OUT        = 4,
  parameter int N_CH         = 2,
  parameter int SETTLE       = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic [N_IN-1:0]       o_x,
  input  logic [N_CH*N_OUT-1:0] i_y,
  output logic [N_IN-1:0]       o_rom_addr,
  input  logic [N_OUT-1:0]      i_rom_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_error,
  output logic [N_IN:0]         o_err_count,
  output logic [N_IN-1:0]       o_first_fail_idx,
  output logic [N_CH-1:0]       o_first_fail_mask
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [SW-1:0]   wait_cnt;
  logic [N_CH-1:0] mask;
  logic            any_fail;
  logic [N_IN:0]   err_next;

  // Case inequality makes X/Z on a channel a mismatch in simulation.
  always_comb begin
    mask = '0;
    for (int c = 0; c < N_CH; c++) begin
      mask[c] = (i_y[c*N_OUT +: N_OUT] !== i_rom_data);
    end
  end

  assign any_fail   = |mask;
  assign err_next   = o_err_count + {{N_IN{1'b0}}, any_fail};
  assign o_rom_addr = o_x;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      idx               <= '0;
      wait_cnt          <= '0;
      o_x               <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_pass            <= 1'b0;
      o_error           <= 1'b0;
      o_err_count       <= '0;
      o_first_fail_idx  <= '0;
      o_first_fail_mask <= '0;
    end else begin
      o_error <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            idx               <= '0;
            o_err_count       <= '0;
            o_first_fail_idx  <= '0;
            o_first_fail_mask <= '0;
            o_done            <= 1'b0;
            o_pass            <= 1'b0;
            o_busy            <= 1'b1;
            state             <= S_APPLY;
          end
        end
        S_APPLY: begin
          o_x      <= idx;
          wait_cnt <= SW'(SETTLE - 1);
          state    <= S_SETTLE;
        end
        S_SETTLE: begin
          if (wait_cnt == '0) state <= S_CHECK;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        S_CHECK: begin
          if (any_fail) begin
            o_error     <= 1'b1;
            o_err_count <= err_next;
            if (o_err_count == '0) begin
              o_first_fail_idx  <= idx;
              o_first_fail_mask <= mask;
            end
          end
          // The terminal vector ends the sweep before idx can wrap.
          if (idx == LAST_IDX || (STOP_ON_FAIL != 0 && any_fail)) begin
            state  <= S_DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            o_pass <= (err_next == '0);
          end else begin
            idx   <= idx + 1'b1;
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for the sweep checker: one instance with STOP_ON_FAIL=0 and one with STOP_ON_FAIL=1, a golden ROM model, and fault-injected implementations.
module tb_tt_sweep_checker;
  localparam int NI = 4, NO = 2, NC = 2, ST = 1, NV = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start [2];
  logic [3:0] x     [2];
  logic [3:0] ra    [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic       err   [2];
  logic [4:0] cnt   [2];
  logic [3:0] ffi   [2];
  logic [1:0] ffm   [2];

  logic [1:0] rom [NV];
  logic [3:0] fx  [2][NV];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [1:0] rd;
      logic [3:0] y;
      always @(posedge clk) rd <= rom[ra[gi]];
      assign y = {rom[x[gi]], rom[x[gi]]} ^ fx[gi][x[gi]];
      tt_sweep_checker #(
        .N_IN(NI), .N_OUT(NO), .N_CH(NC), .SETTLE(ST), .STOP_ON_FAIL(gi)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start[gi]), .o_x(x[gi]), .i_y(y),
        .o_rom_addr(ra[gi]), .i_rom_data(rd), .o_busy(busy[gi]), .o_done(done[gi]),
        .o_pass(pass[gi]), .o_error(err[gi]), .o_err_count(cnt[gi]),
        .o_first_fail_idx(ffi[gi]), .o_first_fail_mask(ffm[gi])
      );
    end
  endgenerate

  typedef struct {
    int cnt; int ffi; int ffm; int last; int pass; int lat; int acc;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: walk the truth table, evaluating each implementation against the golden word.
  function automatic exp_t model(int inst);
    exp_t e;
    logic [1:0] impl;
    int m;
    bit stopped;
    e.cnt = 0; e.ffi = 0; e.ffm = 0; e.last = NV - 1; e.acc = 0;
    stopped = 1'b0;
    for (int v = 0; v < NV && !stopped; v++) begin
      m = 0;
      for (int c = 0; c < NC; c++) begin
        impl = rom[v] ^ fx[inst][v][c*2 +: 2];
        if (impl != rom[v]) m = m | (1 << c);
      end
      if (m != 0) begin
        if (e.cnt == 0) begin e.ffi = v; e.ffm = m; end
        e.cnt++;
        if (inst == 1) begin e.last = v; stopped = 1'b1; end
      end
    end
    e.pass = (e.cnt == 0) ? 1 : 0;
    e.lat  = (ST + 2) * (e.last + 1) + 1;
    return e;
  endfunction

  // Monitor: error pulses are counted and, on each rising o_done, compared against the oldest expectation.
  int   pulses [2];
  logic done_d [2];
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        pulses[i] = 0;
        done_d[i] = 1'b0;
      end else begin
        if (err[i]) pulses[i]++;
        if (done[i] && !done_d[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("latency",    cyc - e.acc + 1, e.lat);
            chk("err_count",  int'(cnt[i]),    e.cnt);
            chk("first_idx",  int'(ffi[i]),    e.ffi);
            chk("first_mask", int'(ffm[i]),    e.ffm);
            chk("pass",       int'(pass[i]),   e.pass);
            chk("x_last",     int'(x[i]),      e.last);
            chk("busy_done",  int'(busy[i]),   0);
            chk("err_pulses", pulses[i],       e.cnt);
          end
          pulses[i] = 0;
        end
        done_d[i] = done[i];
      end
    end
  end

  task automatic randomize_rom();
    for (int v = 0; v < NV; v++) rom[v] = 2'($urandom);
  endtask

  task automatic clear_faults(int inst);
    for (int v = 0; v < NV; v++) fx[inst][v] = 4'h0;
  endtask

  task automatic start_sweep(int inst, bit push);
    exp_t e;
    @(negedge clk);
    start[inst] = 1'b1;
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
    if (push) begin
      e = model(inst);
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(int inst);
    int t = 0;
    do begin @(negedge clk); t++; end while (!done[inst] && t < 400);
    chk("done_seen", int'(done[inst]), 1);
    @(negedge clk);
    if (t >= 400) exp_q.delete();
  endtask

  task automatic wait_x(int inst, int val);
    int t = 0;
    do begin @(negedge clk); t++; end while (int'(x[inst]) != val && t < 400);
    chk("wait_x", int'(x[inst]), val);
  endtask

  task automatic check_zero(int inst, string tag);
    chk({tag, "_x"},    int'(x[inst]),    0);
    chk({tag, "_addr"}, int'(ra[inst]),   0);
    chk({tag, "_busy"}, int'(busy[inst]), 0);
    chk({tag, "_done"}, int'(done[inst]), 0);
    chk({tag, "_pass"}, int'(pass[inst]), 0);
    chk({tag, "_err"},  int'(err[inst]),  0);
    chk({tag, "_cnt"},  int'(cnt[inst]),  0);
    chk({tag, "_ffi"},  int'(ffi[inst]),  0);
    chk({tag, "_ffm"},  int'(ffm[inst]),  0);
  endtask

  task automatic run(int inst);
    start_sweep(inst, 1'b1);
    wait_done(inst);
  endtask

  initial begin
    start[0] = 1'b0;
    start[1] = 1'b0;
    randomize_rom();
    clear_faults(0);
    clear_faults(1);

    // Reset held with start asserted.
    rst_n = 1'b0; start[0] = 1'b1; start[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_zero(0, "rst");
      chk("rst_busy1", int'(busy[1]), 0);
    end
    start[0] = 1'b0; start[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Clean sweep.
    run(0);

    // Channel-1 faults at vectors 5 and 9, with and without stop-on-fail.
    fx[0][5] = {2'($urandom_range(1, 3)), 2'b00};
    fx[0][9] = {2'($urandom_range(1, 3)), 2'b00};
    fx[1][5] = fx[0][5];
    fx[1][9] = fx[0][9];
    run(0);
    run(1);

    // Both channels faulty at vector 0.
    clear_faults(0);
    fx[0][0] = {2'($urandom_range(1, 3)), 2'($urandom_range(1, 3))};
    run(0);

    // Random ROM contents and sparse random faults.
    for (int k = 0; k < 8; k++) begin
      int inst;
      inst = int'($urandom_range(0, 1));
      randomize_rom();
      for (int v = 0; v < NV; v++)
        fx[inst][v] = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      run(inst);
    end

    // A start pulse in mid-sweep must be ignored.
    clear_faults(0);
    fx[0][12] = 4'b0001;
    start_sweep(0, 1'b1);
    wait_x(0, 3);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0);

    // Reset at vector 7 aborts the sweep.
    clear_faults(0);
    start_sweep(0, 1'b0);
    wait_x(0, 7);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero(0, "abort");
    rst_n = 1'b1;
    @(negedge clk);

    // A failing run, then a restart from DONE with clean implementations.
    fx[0][2]  = 4'b0100;
    fx[0][15] = 4'b0011;
    run(0);
    clear_faults(0);
    run(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
